// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW,
            OP_ORI, OP_LUI, OP_J, OP_JAL, OP_JR: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_e      state_q;
    state_e      state_d;
    logic        mem_req_s;
    logic        mem_we_s;
    logic        iord_s;
    logic        ir_write_s;
    logic        pc_write_s;
    logic [1:0]  pc_src_s;
    logic        reg_write_s;
    logic        illegal_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d     = state_q;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        iord_s      = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc_src_s    = 2'd0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                if (op_is_legal(opcode)) begin
                    state_d   = S_EXEC;
                end else begin
                    illegal_s = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_RTYPE, OP_ORI, OP_LUI: state_d = S_WB;
                    OP_LW, OP_SW:             state_d = S_MEM;
                    OP_BEQ: begin
                        if (alu_zero) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'd1;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                    end
                    OP_BNE: begin
                        if (!alu_zero) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'd1;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                    end
                    OP_J: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'd2;
                    end
                    OP_JAL: begin
                        pc_write_s  = 1'b1;
                        pc_src_s    = 2'd2;
                        reg_write_s = 1'b1;
                    end
                    OP_JR: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'd3;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                mem_we_s  = (opcode == OP_SW);
                if (mem_ready) begin
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are Mealy decodes; rst_n gates them so reset silences the bus even mid-access.
    assign mem_req   = rst_n & mem_req_s;
    assign mem_we    = rst_n & mem_we_s;
    assign iord      = rst_n & iord_s;
    assign ir_write  = rst_n & ir_write_s;
    assign pc_write  = rst_n & pc_write_s;
    assign pc_src    = {2{rst_n}} & pc_src_s;
    assign reg_write = rst_n & reg_write_s;
    assign illegal   = rst_n & illegal_s;
    assign state     = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;
    logic        instr_done_s;

    assign instr_done_s = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
                          && (state_d == S_FETCH);

    // Free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_done_s) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end else begin
                instr_cnt_q <= instr_cnt_q;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-instruction expected traces built from the
// instruction class, compared against the DUT every cycle.
module tb_multicycle_sequencer;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_JR  = 6'b001000;
    localparam logic [5:0] OP_IL1 = 6'b111111;
    localparam logic [5:0] OP_IL2 = 6'b000001;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       mr;
        logic       req;
        logic       we;
        logic       io;
        logic       irw;
        logic       pcw;
        logic [1:0] src;
        logic       rw;
        logic       ill;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_cyc;
    logic [31:0] m_instr;
    rec_t        tq[$];
    rec_t        e;

    multicycle_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .state     (state),
        .illegal   (illegal),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [5:0] op);
        return op inside {OP_R, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ORI, OP_LUI, OP_J, OP_JAL, OP_JR};
    endfunction

    function automatic rec_t mk(input logic [2:0] st, input logic mr, input logic req,
                                input logic we, input logic io, input logic irw,
                                input logic pcw, input logic [1:0] src, input logic rw,
                                input logic ill);
        rec_t r;
        r.st = st; r.mr = mr; r.req = req; r.we = we; r.io = io;
        r.irw = irw; r.pcw = pcw; r.src = src; r.rw = rw; r.ill = ill;
        return r;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace of one instruction, from its class and the wait counts
    task automatic build(input logic [5:0] op, input logic z, input int fw, input int mw);
        logic       pcw;
        logic [1:0] src;
        logic       rw;
        tq.delete();
        for (int i = 0; i < fw; i++) tq.push_back(mk(ST_F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
        tq.push_back(mk(ST_F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        tq.push_back(mk(ST_D, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, !legal(op)));
        if (!legal(op)) return;
        pcw = 1'b0; src = 2'd0; rw = 1'b0;
        if ((op == OP_BEQ && z) || (op == OP_BNE && !z)) begin pcw = 1'b1; src = 2'd1; end
        if (op == OP_J || op == OP_JAL) begin pcw = 1'b1; src = 2'd2; end
        if (op == OP_JAL) rw = 1'b1;
        if (op == OP_JR) begin pcw = 1'b1; src = 2'd3; end
        tq.push_back(mk(ST_E, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, pcw, src, rw, 1'b0));
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < mw; i++) tq.push_back(mk(ST_M, 1'b0, 1'b1, op == OP_SW, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
            tq.push_back(mk(ST_M, 1'b1, 1'b1, op == OP_SW, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
        end
        if (op inside {OP_R, OP_ORI, OP_LUI, OP_LW})
            tq.push_back(mk(ST_W, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cyc();
`ifdef SEQ_PERF_CNT_EN
        return m_cyc;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_instr();
`ifdef SEQ_PERF_CNT_EN
        return m_instr;
`else
        return 32'd0;
`endif
    endfunction

    task automatic cmp_rec(input rec_t r);
        chk("state",     32'(state),     32'(r.st));
        chk("mem_req",   32'(mem_req),   32'(r.req));
        chk("mem_we",    32'(mem_we),    32'(r.we));
        chk("iord",      32'(iord),      32'(r.io));
        chk("ir_write",  32'(ir_write),  32'(r.irw));
        chk("pc_write",  32'(pc_write),  32'(r.pcw));
        chk("pc_src",    32'(pc_src),    32'(r.src));
        chk("reg_write", 32'(reg_write), 32'(r.rw));
        chk("illegal",   32'(illegal),   32'(r.ill));
        chk("cycle_cnt", cycle_cnt, exp_cyc());
        chk("instr_cnt", instr_cnt, exp_instr());
    endtask

    task automatic drive(input rec_t r, input logic [5:0] op, input logic z);
        opcode    = (r.st == ST_F) ? 6'($urandom_range(0, 63)) : op;
        alu_zero  = (r.st == ST_E) ? z : rbit();
        mem_ready = r.mr;
    endtask

    // One cycle: drive at negedge, compare mid-low-phase, then cross the rising edge
    task automatic step(input logic [5:0] op, input logic z);
        e = tq.pop_front();
        drive(e, op, z);
        #2;
        cmp_rec(e);
        @(posedge clk);
        m_cyc = m_cyc + 32'd1;
        @(negedge clk);
    endtask

    task automatic run(input logic [5:0] op, input logic z, input int fw, input int mw);
        build(op, z, fw, mw);
        while (tq.size() > 0) step(op, z);
        if (legal(op)) m_instr = m_instr + 32'd1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_SW; alu_zero = 1'b1; mem_ready = 1'b1;
        m_cyc = 32'd0; m_instr = 32'd0;
        @(negedge clk);
        #2;
        cmp_rec(mk(ST_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));

        // Hand-computed trace lengths and key cycles pin the model
        build(OP_R, 1'b0, 0, 0);   chk("pin_r_len",  32'(tq.size()), 32'd4); chk("pin_r_wb", 32'(tq[3].rw), 32'd1);
        build(OP_LW, 1'b0, 0, 2);  chk("pin_lw_len", 32'(tq.size()), 32'd7); chk("pin_lw_c7", 32'(tq[6].st), 32'd4);
        build(OP_SW, 1'b0, 0, 0);  chk("pin_sw_len", 32'(tq.size()), 32'd4);
        build(OP_JAL, 1'b0, 0, 0); chk("pin_jal_len", 32'(tq.size()), 32'd3); chk("pin_jal_src", 32'(tq[2].src), 32'd2);
        build(OP_IL1, 1'b0, 0, 0); chk("pin_ill_len", 32'(tq.size()), 32'd2); chk("pin_ill", 32'(tq[1].ill), 32'd1);
        tq.delete();

        @(negedge clk);
        rst_n = 1'b1;
        run(OP_R,   1'b0, 0, 0);
        run(OP_ORI, 1'b1, 0, 0);
        run(OP_LUI, 1'b0, 2, 0);
        run(OP_LW,  1'b0, 0, 2);
        run(OP_SW,  1'b1, 1, 1);
        run(OP_BEQ, 1'b1, 0, 0);
        run(OP_BEQ, 1'b0, 0, 0);
        run(OP_BNE, 1'b0, 0, 0);
        run(OP_BNE, 1'b1, 1, 0);
        run(OP_J,   1'b0, 0, 0);
        run(OP_JAL, 1'b1, 0, 0);
        run(OP_JR,  1'b0, 0, 0);
        run(OP_IL1, 1'b0, 0, 0);
        run(OP_IL2, 1'b1, 1, 0);
        run(OP_LW,  1'b1, 3, 0);
        run(OP_SW,  1'b0, 0, 0);

        // Reset dropped while a store is waiting in MEM
        build(OP_SW, 1'b0, 0, 3);
        for (int i = 0; i < 3; i++) step(OP_SW, 1'b0);
        e = tq.pop_front();
        drive(e, OP_SW, 1'b0);
        #2;
        cmp_rec(e);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we",  32'(mem_we),  32'd0);
        chk("rst_iord",    32'(iord),    32'd0);
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_cyc",     cycle_cnt,    32'd0);
        chk("rst_instr",   instr_cnt,    32'd0);
        tq.delete();
        m_cyc = 32'd0; m_instr = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        run(OP_R, 1'b0, 0, 0);
        run(OP_R, 1'b1, 0, 0);
        run(OP_R, 1'b0, 0, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("cnt_cyc12",  cycle_cnt, 32'd12);
        chk("cnt_instr3", instr_cnt, 32'd3);
        dut.cycle_cnt_q = 32'hFFFF_FFFF;
        dut.instr_cnt_q = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF; m_instr = 32'hFFFF_FFFF;
        run(OP_R, 1'b0, 0, 0);
        chk("wrap_cyc",   cycle_cnt, 32'd3);
        chk("wrap_instr", instr_cnt, 32'd0);
`else
        chk("cnt_off_cyc",   cycle_cnt, 32'd0);
        chk("cnt_off_instr", instr_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction opcode from the IR output, valid from DECODE onward.
REQ-004 SHALL have port alu_zero, input, 1 bit: ALU zero flag, sampled in EXEC.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completion, sampled only while mem_req=1.
REQ-006 SHALL have port mem_req, output, 1 bit: memory access request, held until accepted.
REQ-007 SHALL have port mem_we, output, 1 bit: write qualifier for mem_req.
REQ-008 SHALL have port iord, output, 1 bit: memory address select; 0=PC, 1=ALU result.
REQ-009 SHALL have ports ir_write and pc_write, outputs, 1 bit each: IR load strobe and PC load strobe.
REQ-010 SHALL have port pc_src, output, 2 bits: PC source; 0=PC+4, 1=branch target, 2=jump target, 3=register rs.
REQ-011 SHALL have port reg_write, output, 1 bit: register-file write strobe.
REQ-012 SHALL have port state, output, 3 bits: current state encoding.
REQ-013 SHALL have port illegal, output, 1 bit: one-cycle pulse on an undecodable opcode.
REQ-014 SHALL have ports cycle_cnt and instr_cnt, outputs, 32 bits each: performance counters (see Configuration).

Function
REQ-015 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL return to FETCH on the next edge.
REQ-016 FETCH: SHALL assert mem_req=1, iord=0, mem_we=0; SHALL stay in FETCH while mem_ready=0; on mem_ready=1 SHALL pulse ir_write=1, pc_write=1 with pc_src=0 in that cycle, then go to DECODE.
REQ-017 DECODE: SHALL last exactly one cycle; legal opcodes are 000000, 000100, 000101, 100011, 101011, 001101, 001111, 000010, 000011, 001000; legal -> EXEC; any other opcode -> pulse illegal=1, go to FETCH.
REQ-018 EXEC for R-type, 001101 (ori) and 001111 (lui): SHALL go to WB.
REQ-019 EXEC for lw and sw: SHALL go to MEM.
REQ-020 EXEC for beq: SHALL assert pc_write=1, pc_src=1 only when alu_zero=1, then go to FETCH.
REQ-021 EXEC for bne: SHALL assert pc_write=1, pc_src=1 only when alu_zero=0, then go to FETCH.
REQ-022 EXEC for j: SHALL assert pc_write=1, pc_src=2, then go to FETCH.
REQ-023 EXEC for jal: SHALL assert pc_write=1, pc_src=2 and reg_write=1 (link), then go to FETCH.
REQ-024 EXEC for jr: SHALL assert pc_write=1, pc_src=3, then go to FETCH.
REQ-025 MEM: SHALL assert mem_req=1, iord=1, with mem_we=1 for sw; SHALL hold while mem_ready=0; on mem_ready=1, sw -> FETCH, lw -> WB.
REQ-026 WB: SHALL assert reg_write=1 for exactly one cycle, then go to FETCH.
REQ-027 With mem_ready tied to 1, latency in cycles SHALL be: branch/j/jal/jr 3, R/ori/lui/sw 4, lw 5; each wait cycle SHALL add exactly one cycle.
REQ-028 Strobes (ir_write, pc_write, reg_write, illegal) SHALL be 0 in every state and condition not listed above; pc_src and iord SHALL be 0 when unused.
REQ-029 mem_req and mem_we SHALL remain stable while waiting for mem_ready; mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=FETCH and all strobes, mem_req, mem_we, iord and pc_src to 0, and both counters to 0, including mid-access.
REQ-031 After rst_n rises, FETCH SHALL assert mem_req=1 on the first clock edge.

Configuration
REQ-032 With macro SEQ_PERF_CNT_EN defined: cycle_cnt SHALL increment every cycle out of reset; instr_cnt SHALL increment on each return to FETCH from EXEC, MEM or WB; both SHALL wrap 0xFFFFFFFF->0.
REQ-033 Without SEQ_PERF_CNT_EN: counter logic SHALL be absent, and cycle_cnt and instr_cnt SHALL be constant 0.

Verification
REQ-034 Verify: mem_ready=1, opcode=000000 -> FETCH,DECODE,EXEC,WB; reg_write=1 only in WB; 4 cycles.
REQ-035 Verify: opcode=100011, mem_ready low 2 cycles in MEM -> mem_req=1, iord=1 held; WB reached on cycle 7.
REQ-036 Verify: opcode=000100 with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC; alu_zero=0 -> no pc_write in EXEC; opcode=000101 -> inverse behaviour.
REQ-037 Verify: opcode=000011 -> pc_src=2, pc_write=1, reg_write=1 in the same EXEC cycle; opcode=111111 -> illegal=1 in DECODE, next state FETCH.
REQ-038 Verify: rst_n dropped mid-MEM while mem_we=1 -> mem_req=0 and mem_we=0 immediately, before any clock edge; state=0.
REQ-039 Verify (SEQ_PERF_CNT_EN): 3 R-type instructions from reset with mem_ready=1 -> instr_cnt=3, cycle_cnt=12; counter preloaded to 0xFFFFFFFF wraps to 0.
